// File: rtl/gray_state_monitor.sv
// Tracks the 32-state Gray-coded sequencer: step/lap pulses, dwell/stall, sticky error flags.
// Define PARITY_CHECK_EN to compile the out_signal parity check (err_parity tied low otherwise).
module gray_state_monitor #(
  parameter int DWELL_W     = 16,
  parameter int LAP_W       = 8,
  parameter int STALL_LIMIT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         state_in,
  input  logic               out_signal_in,
  input  logic               err_clr,
  output logic [4:0]         bin_state,
  output logic               step_pulse,
  output logic               lap_pulse,
  output logic [LAP_W-1:0]   lap_count,
  output logic [DWELL_W-1:0] dwell_count,
  output logic               stall,
  output logic               err_skip,
  output logic               err_backward,
  output logic               err_parity
);

  typedef enum logic [1:0] {PRIME, TRACK, STALLED} fsm_e;

  localparam logic [DWELL_W-1:0] STALL_LIM = DWELL_W'(STALL_LIMIT);

  fsm_e               fsm_q;
  logic [4:0]         s_q, prev_q, bin_q;
  logic               s_v_q;
  logic               step_q, lap_q, stall_q;
  logic               skip_q, bwd_q, par_err_q;
  logic [LAP_W-1:0]   lap_cnt_q;
  logic [DWELL_W-1:0] dwell_q;

  logic [4:0]         cur_d, delta_d;
  logic [DWELL_W-1:0] dwell_d;
  logic               par_mis_d;

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    cur_d   = g2b(s_q);
    delta_d = cur_d - prev_q;
    dwell_d = (&dwell_q) ? dwell_q : dwell_q + 1'b1;
  end

`ifdef PARITY_CHECK_EN
  logic par_q;
  always_ff @(posedge clk) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= out_signal_in;
  end
  // Compared against the Gray bits captured on the same edge as par_q.
  assign par_mis_d = par_q ^ (^s_q[2:0]);
`else
  logic par_unused;
  assign par_unused = out_signal_in;
  assign par_mis_d  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q     <= PRIME;
      s_q       <= '0;
      s_v_q     <= 1'b0;
      prev_q    <= '0;
      bin_q     <= '0;
      step_q    <= 1'b0;
      lap_q     <= 1'b0;
      stall_q   <= 1'b0;
      skip_q    <= 1'b0;
      bwd_q     <= 1'b0;
      par_err_q <= 1'b0;
      lap_cnt_q <= '0;
      dwell_q   <= '0;
    end else begin
      s_q       <= state_in;
      s_v_q     <= 1'b1;
      step_q    <= 1'b0;
      lap_q     <= 1'b0;
      // Clear first; any set below overrides so a same-cycle error wins.
      skip_q    <= skip_q & ~err_clr;
      bwd_q     <= bwd_q & ~err_clr;
      par_err_q <= par_err_q & ~err_clr;
      case (fsm_q)
        PRIME: begin
          if (s_v_q) begin
            prev_q  <= cur_d;
            bin_q   <= cur_d;
            dwell_q <= '0;
            stall_q <= 1'b0;
            fsm_q   <= TRACK;
          end
        end
        default: begin
          if (par_mis_d) par_err_q <= 1'b1;
          if (delta_d == 5'd0) begin
            dwell_q <= dwell_d;
            if (dwell_d >= STALL_LIM) begin
              fsm_q   <= STALLED;
              stall_q <= 1'b1;
            end
          end else begin
            prev_q  <= cur_d;
            bin_q   <= cur_d;
            dwell_q <= '0;
            stall_q <= 1'b0;
            fsm_q   <= TRACK;
            if (delta_d == 5'd1) begin
              step_q <= 1'b1;
              if (cur_d == 5'd0) begin
                lap_q     <= 1'b1;
                lap_cnt_q <= lap_cnt_q + 1'b1;
              end
            end else if (delta_d == 5'd31) begin
              bwd_q <= 1'b1;
            end else begin
              skip_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bin_state    = bin_q;
  assign step_pulse   = step_q;
  assign lap_pulse    = lap_q;
  assign lap_count    = lap_cnt_q;
  assign dwell_count  = dwell_q;
  assign stall        = stall_q;
  assign err_skip     = skip_q;
  assign err_backward = bwd_q;
  assign err_parity   = par_err_q;

endmodule

// File: tb/tb_gray_state_monitor.sv
// Bench for gray_state_monitor: directed table, hand sequences and random stimulus vs a reference model.
module tb_gray_state_monitor;

  localparam int DW   = 5;
  localparam int LW   = 3;
  localparam int LIM  = 10;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    state_in = '0;
  logic          out_sig = 1'b0;
  logic          err_clr = 1'b0;
  logic [4:0]    bin_state;
  logic          step_pulse, lap_pulse, stall, err_skip, err_backward, err_parity;
  logic [LW-1:0] lap_count;
  logic [DW-1:0] dwell_count;

  gray_state_monitor #(.DWELL_W(DW), .LAP_W(LW), .STALL_LIMIT(LIM)) dut (
    .clk(clk), .reset(rst_n), .state_in(state_in), .out_signal_in(out_sig),
    .err_clr(err_clr), .bin_state(bin_state), .step_pulse(step_pulse),
    .lap_pulse(lap_pulse), .lap_count(lap_count), .dwell_count(dwell_count),
    .stall(stall), .err_skip(err_skip), .err_backward(err_backward),
    .err_parity(err_parity)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, in plain integers.
  int m_sv, m_s, m_par, m_primed, m_prev, m_bin, m_step, m_lap, m_laps;
  int m_dwell, m_stall, m_skip, m_bwd, m_perr;

  function automatic logic [4:0] gray(input int n);
    return 5'(n ^ (n >> 1));
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    for (int k = 0; k < 5; k++) b = b ^ (g >> k);
    return b & 31;
  endfunction

  function automatic logic par_of(input logic [4:0] g);
    return g[0] ^ g[1] ^ g[2];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int r, input int g, input int o, input int clr);
    int cur, d;
    if (r == 0) begin
      m_sv = 0; m_s = 0; m_par = 0; m_primed = 0; m_prev = 0; m_bin = 0;
      m_step = 0; m_lap = 0; m_laps = 0; m_dwell = 0; m_stall = 0;
      m_skip = 0; m_bwd = 0; m_perr = 0;
    end else begin
      m_step = 0; m_lap = 0;
      if (clr != 0) begin m_skip = 0; m_bwd = 0; m_perr = 0; end
      if (m_sv != 0) begin
        cur = g2b(m_s);
        if (m_primed == 0) begin
          m_prev = cur; m_bin = cur; m_dwell = 0; m_primed = 1;
        end else begin
`ifdef PARITY_CHECK_EN
          if (m_par != ((m_s ^ (m_s >> 1) ^ (m_s >> 2)) & 1)) m_perr = 1;
`endif
          d = (cur - m_prev + 32) % 32;
          if (d == 0) begin
            m_dwell = (m_dwell == DMAX) ? DMAX : m_dwell + 1;
          end else begin
            m_dwell = 0;
            if (d == 1) begin
              m_step = 1;
              if (cur == 0) begin m_lap = 1; m_laps = (m_laps + 1) % (1 << LW); end
            end else if (d == 31) m_bwd = 1;
            else m_skip = 1;
            m_prev = cur; m_bin = cur;
          end
        end
      end
      m_stall = (m_dwell >= LIM) ? 1 : 0;
      m_s = g; m_par = o; m_sv = 1;
    end
  endtask

  task automatic compare_all();
    chk("bin_state", bin_state, m_bin);
    chk("step_pulse", step_pulse, m_step);
    chk("lap_pulse", lap_pulse, m_lap);
    chk("lap_count", lap_count, m_laps);
    chk("dwell_count", dwell_count, m_dwell);
    chk("stall", stall, m_stall);
    chk("err_skip", err_skip, m_skip);
    chk("err_backward", err_backward, m_bwd);
    chk("err_parity", err_parity, m_perr);
  endtask

  // One clock: drive, model the edge, sample on the falling edge.
  task automatic cyc(input logic r, input logic [4:0] g, input logic o, input logic clr);
    rst_n = r; state_in = g; out_sig = o; err_clr = clr;
    @(posedge clk);
    model_edge(int'(r), int'(g), int'(o), int'(clr));
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycp(input logic r, input logic [4:0] g, input logic clr);
    cyc(r, g, par_of(g), clr);
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] g;
    logic       clr;
    logic [4:0] bin;
    logic       step, skip, bwd;
  } vec_t;

  vec_t tbl[14];
  int   nsteps, nlaps, idx, sel;
  logic o_r, c_r, r_r;

  initial begin
    tbl[0]  = '{1'b0, 5'd7,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd7,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd4,  1'b0, 5'd5, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 5'd4,  1'b0, 5'd7, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 5'd12, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 5'd12, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 5'd12, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 5'd5,  1'b0, 5'd8, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 5'd7,  1'b0, 5'd6, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 5'd7,  1'b1, 5'd5, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 5'd6,  1'b0, 5'd5, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 5'd6,  1'b1, 5'd4, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 5'd6,  1'b1, 5'd4, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 5'd6,  1'b0, 5'd4, 1'b0, 1'b0, 1'b0};

    // Reset with 0 held: prime after two edges, dwell counts from there.
    cycp(1'b0, 5'd0, 1'b0);
    chk("reset_bin", bin_state, 0);
    chk("reset_dwell", dwell_count, 0);
    cycp(1'b1, 5'd0, 1'b0);
    cycp(1'b1, 5'd0, 1'b0);
    chk("prime_bin", bin_state, 0);
    chk("prime_dwell", dwell_count, 0);
    cycp(1'b1, 5'd0, 1'b0);
    chk("dwell_1", dwell_count, 1);
    cycp(1'b1, 5'd0, 1'b0);
    chk("dwell_2", dwell_count, 2);

    // Full lap walk, 4 cycles per state.
    nsteps = 0; nlaps = 0;
    for (int n = 1; n <= 32; n++) begin
      for (int k = 0; k < 4; k++) begin
        cycp(1'b1, gray(n % 32), 1'b0);
        nsteps += int'(step_pulse);
        nlaps  += int'(lap_pulse);
        if (lap_pulse) chk("lap_with_step", step_pulse, 1);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cycp(1'b1, gray(0), 1'b0);
      nsteps += int'(step_pulse);
      nlaps  += int'(lap_pulse);
    end
    chk("walk_steps", nsteps, 32);
    chk("walk_laps", nlaps, 1);
    chk("walk_lap_count", lap_count, 1);
    chk("walk_no_err", {err_skip, err_backward, err_parity}, 0);

    // Directed skip / backward / err_clr table.
    foreach (tbl[i]) begin
      cycp(tbl[i].rst, tbl[i].g, tbl[i].clr);
      chk($sformatf("tbl%0d_bin", i), bin_state, tbl[i].bin);
      chk($sformatf("tbl%0d_step", i), step_pulse, tbl[i].step);
      chk($sformatf("tbl%0d_skip", i), err_skip, tbl[i].skip);
      chk($sformatf("tbl%0d_bwd", i), err_backward, tbl[i].bwd);
    end

    // Stall on Gray(3), saturation, then recovery on Gray(4).
    cycp(1'b0, gray(3), 1'b0);
    cycp(1'b1, gray(3), 1'b0);
    cycp(1'b1, gray(3), 1'b0);
    for (int k = 1; k <= 35; k++) begin
      cycp(1'b1, gray(3), 1'b0);
      if (k == 9)  chk("stall_before_limit", stall, 0);
      if (k == 10) begin
        chk("stall_at_limit", stall, 1);
        chk("dwell_at_limit", dwell_count, 10);
      end
    end
    chk("dwell_saturated", dwell_count, DMAX);
    chk("stall_held", stall, 1);
    cycp(1'b1, gray(4), 1'b0);
    cycp(1'b1, gray(4), 1'b0);
    chk("unstall_step", step_pulse, 1);
    chk("unstall_stall", stall, 0);
    chk("unstall_dwell", dwell_count, 0);

    // Reset mid-walk at Gray(12).
    for (int n = 5; n <= 12; n++) cycp(1'b1, gray(n), 1'b0);
    cycp(1'b0, gray(12), 1'b0);
    chk("midreset_outs", {bin_state, step_pulse, lap_pulse, lap_count, dwell_count,
                          stall, err_skip, err_backward, err_parity}, 0);
    cycp(1'b1, gray(12), 1'b0);
    chk("midreset_prime_bin", bin_state, 0);

    // Parity: 00010 has bits[2:0] XOR = 1.
    cyc(1'b0, 5'b00010, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 5'b00010, 1'b0, 1'b0);
`ifdef PARITY_CHECK_EN
    chk("parity_bad", err_parity, 1);
`else
    chk("parity_bad", err_parity, 0);
`endif
    cyc(1'b0, 5'b00010, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 5'b00010, 1'b1, 1'b0);
    chk("parity_good", err_parity, 0);

    // Random traffic, mostly legal steps with holds and injected faults.
    idx = 0;
    for (int t = 0; t < 4000; t++) begin
      sel = $urandom_range(0, 99);
      if (sel >= 50 && sel < 80) idx = (idx + 1) % 32;
      else if (sel >= 80 && sel < 87) idx = (idx + 31) % 32;
      else if (sel >= 87 && sel < 94) idx = $urandom_range(0, 31);
      o_r = par_of(gray(idx)) ^ ($urandom_range(0, 19) == 0);
      c_r = ($urandom_range(0, 9) == 0);
      r_r = ($urandom_range(0, 299) != 0);
      cyc(r_r, gray(idx), o_r, c_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
